// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared size/master encodings, response record and lane-mask helper for dmem_arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} mid_e;
    typedef struct packed {
        logic       valid;
        mid_e       owner;
        logic [1:0] size;
        logic [1:0] off;
        logic       uns;
        logic       err;
        logic       is_load;
    } rsp_t;
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_W ? 4'hF : size == SZ_H ? 4'b0011 << off : size == SZ_B ? 4'b0001 << off : 4'h0;
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/grant/response bundle.
interface dmem_arbiter_if;
    logic        req, we, uns, gnt, rvalid, err;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    modport master(output req, we, size, uns, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave(input req, we, size, uns, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: extracts a byte/half/word lane from a RAM word and sign- or zero-extends it.
import dmem_arb_pkg::*;
module dmem_load_align (
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        data = size == SZ_B ? {{24{b[7] & ~uns}}, b} : size == SZ_H ? {{16{h[15] & ~uns}}, h} : word;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the byte-lane data RAM; define DMEM_ARB_RR_EN for round-robin instead of fixed priority.
import dmem_arb_pkg::*;
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          AW           = 12,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    output logic [3:0]     ram_w_en,
    output logic [31:0]    ram_w_addr,
    output logic [31:0]    ram_w_data,
    output logic           ram_r_en,
    output logic [31:0]    ram_r_addr,
    input  logic [31:0]    ram_r_data
);
    mid_e        win;
    logic        any, we, uns, legal, in_win;
    logic [1:0]  size;
    logic [31:0] addr, wdata, off_a, ld_data;
    rsp_t        rsp;
`ifdef DMEM_ARB_RR_EN
    mid_e ptr;
    assign win = (m0.req && m1.req) ? ptr : m1.req ? M1 : M0;
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;
    assign win = (m1.req && (!m0.req || starve_cnt == CW'(STARVE_LIMIT))) ? M1 : M0;
`endif
    // gating with rst keeps every combinational enable low while reset is held
    assign any    = rst && (m0.req || m1.req);
    assign m0.gnt = any && win == M0;
    assign m1.gnt = any && win == M1;
    assign we     = win == M1 ? m1.we : m0.we;
    assign uns    = win == M1 ? m1.uns : m0.uns;
    assign size   = win == M1 ? m1.size : m0.size;
    assign addr   = win == M1 ? m1.addr : m0.addr;
    assign wdata  = win == M1 ? m1.wdata : m0.wdata;
    assign off_a  = addr - BASE_ADDR;
    assign in_win = addr >= BASE_ADDR && (off_a >> (AW + 2)) == 32'd0;
    assign legal  = in_win && size != 2'd3 && !(size == SZ_H && addr[0]) && !(size == SZ_W && addr[1:0] != 2'd0);
    assign ram_w_en   = (any && legal && we) ? lane_mask(size, addr[1:0]) : 4'h0;
    assign ram_w_addr = addr;
    assign ram_w_data = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    assign ram_r_en   = any && legal && !we;
    assign ram_r_addr = addr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rsp <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr <= M0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            rsp <= '{valid: any, owner: win, size: size, off: addr[1:0], uns: uns, err: !legal, is_load: !we};
`ifdef DMEM_ARB_RR_EN
            if (any) ptr <= win == M0 ? M1 : M0;
`else
            if (m1.gnt || !m1.req) starve_cnt <= '0;
            else if (m0.gnt) starve_cnt <= starve_cnt + 1'b1;
`endif
        end
    dmem_load_align u_align (.word(ram_r_data), .off(rsp.off), .size(rsp.size), .uns(rsp.uns), .data(ld_data));
    // the response register always drives outputs, even while a new grant overwrites it
    assign m0.rvalid = rsp.valid && rsp.owner == M0;
    assign m1.rvalid = rsp.valid && rsp.owner == M1;
    assign m0.err    = m0.rvalid && rsp.err;
    assign m1.err    = m1.rvalid && rsp.err;
    assign m0.rdata  = (m0.rvalid && rsp.is_load && !rsp.err) ? ld_data : 32'h0;
    assign m1.rdata  = (m1.rvalid && rsp.is_load && !rsp.err) ? ld_data : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural byte-lane RAM.
import dmem_arb_pkg::*;
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic [3:0]  ram_w_en;
    logic [31:0] ram_w_addr, ram_w_data, ram_r_addr, ram_r_data;
    logic        ram_r_en;
    logic [31:0] mem [0:4095];
    int          tests = 0, fails = 0;
    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();
    dmem_arbiter dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_w_en[i]) mem[ram_w_addr[13:2]][8*i +: 8] <= ram_w_data[8*i +: 8];
        if (ram_r_en) ram_r_data <= mem[ram_r_addr[13:2]];
    end

    task automatic idle();
        m0_if.req = 0; m1_if.req = 0;
    endtask

    task automatic drive(input int m, input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (m == 0) begin
            m0_if.req = 1; m0_if.we = we; m0_if.size = sz; m0_if.uns = uns; m0_if.addr = a; m0_if.wdata = wd;
        end else begin
            m1_if.req = 1; m1_if.we = we; m1_if.size = sz; m1_if.uns = uns; m1_if.addr = a; m1_if.wdata = wd;
        end
    endtask

    task automatic test_reset();
        drive(0, 0, SZ_W, 0, 32'h10, 0);
        drive(1, 1, SZ_W, 0, 32'h20, 32'h1);
        #1;
        tests++;
        if ({m0_if.gnt, m1_if.gnt, ram_w_en, ram_r_en} !== 7'b0)
            $display("FAIL reset_enables: got %b want 0", {m0_if.gnt, m1_if.gnt, ram_w_en, ram_r_en});
        @(posedge clk); #1;
        tests++;
        if ({m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err, m0_if.rdata, m1_if.rdata} !== 68'b0) begin
            fails++;
            $display("FAIL reset_rsp: got rv=%b%b err=%b%b rd0=%h rd1=%h want all 0", m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err, m0_if.rdata, m1_if.rdata);
        end
        if ({m0_if.gnt, m1_if.gnt, ram_w_en, ram_r_en} !== 7'b0) fails++;
        @(negedge clk); idle(); rst = 1;
    endtask

    task automatic test_store_load_word();
        @(negedge clk); drive(0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF);
        #1;
        tests++;
        if ({m0_if.gnt, ram_w_en, ram_r_en} !== 6'b1_1111_0 || ram_w_data !== 32'hDEADBEEF || ram_w_addr !== 32'h10) begin
            fails++;
            $display("FAIL st_word: got gnt=%b wen=%h ren=%b wd=%h wa=%h want 1 f 0 deadbeef 10", m0_if.gnt, ram_w_en, ram_r_en, ram_w_data, ram_w_addr);
        end
        @(posedge clk); #1;
        tests++;
        if ({m0_if.rvalid, m0_if.err, m0_if.rdata} !== {2'b10, 32'h0}) begin
            fails++;
            $display("FAIL st_word_rsp: got rv=%b err=%b rd=%h want 1 0 0", m0_if.rvalid, m0_if.err, m0_if.rdata);
        end
        @(negedge clk); drive(0, 0, SZ_W, 0, 32'h10, 0);
        #1;
        tests++;
        if ({m0_if.gnt, ram_r_en, ram_w_en} !== 6'b11_0000 || ram_r_addr !== 32'h10) begin
            fails++;
            $display("FAIL ld_word_issue: got gnt=%b ren=%b wen=%h ra=%h want 1 1 0 10", m0_if.gnt, ram_r_en, ram_w_en, ram_r_addr);
        end
        @(posedge clk); #1;
        tests++;
        if ({m0_if.rvalid, m0_if.err, m0_if.rdata} !== {2'b10, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL ld_word_rsp: got rv=%b err=%b rd=%h want 1 0 deadbeef", m0_if.rvalid, m0_if.err, m0_if.rdata);
        end
        @(negedge clk); idle();
        @(posedge clk); #1;
        tests++;
        if (m0_if.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rvalid_pulse: got %b want 0", m0_if.rvalid);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] a   [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10};
        logic [1:0]  sz  [6] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_B, SZ_W};
        logic        u   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80A5, 32'h00007F01, 32'h0000007F, 32'h80A57F01};
        @(negedge clk); drive(0, 1, SZ_W, 0, 32'h10, 32'h80A57F01);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(0, 0, sz[i], u[i], a[i], 0);
            @(posedge clk); #1;
            tests++;
            if ({m0_if.rvalid, m0_if.err, m0_if.rdata} !== {2'b10, exp[i]}) begin
                fails++;
                $display("FAIL ld_ext[%0d]: got rv=%b err=%b rd=%h want 1 0 %h", i, m0_if.rvalid, m0_if.err, m0_if.rdata, exp[i]);
            end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_store_half();
        @(negedge clk); drive(0, 1, SZ_W, 0, 32'h04, 32'h0);
        @(negedge clk); drive(0, 1, SZ_H, 0, 32'h06, 32'hFFFF1234);
        #1;
        tests++;
        if (ram_w_en !== 4'b1100 || ram_w_data !== 32'h12341234) begin
            fails++;
            $display("FAIL st_half: got wen=%b wd=%h want 1100 12341234", ram_w_en, ram_w_data);
        end
        @(negedge clk); drive(0, 1, SZ_B, 0, 32'h05, 32'h000000AB);
        #1;
        tests++;
        if (ram_w_en !== 4'b0010 || ram_w_data !== 32'hABABABAB) begin
            fails++;
            $display("FAIL st_byte: got wen=%b wd=%h want 0010 abababab", ram_w_en, ram_w_data);
        end
        @(negedge clk); drive(0, 0, SZ_W, 0, 32'h04, 0);
        @(posedge clk); #1;
        tests++;
        if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 32'h1234AB00}) begin
            fails++;
            $display("FAIL st_merge: got rv=%b rd=%h want 1 1234ab00", m0_if.rvalid, m0_if.rdata);
        end
        @(negedge clk); idle();
    endtask

    task automatic test_errors();
        logic [31:0] a  [5] = '{32'h02, 32'h20, 32'h4000, 32'h4000, 32'h03};
        logic [1:0]  sz [5] = '{SZ_W, 2'd3, SZ_W, SZ_W, SZ_H};
        logic        w  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle(); drive(1, w[i], sz[i], 0, a[i], 32'hCAFEF00D);
            #1;
            tests++;
            if ({m1_if.gnt, m0_if.gnt, ram_r_en, ram_w_en} !== 7'b1000000) begin
                fails++;
                $display("FAIL err_issue[%0d]: got gnt1=%b gnt0=%b ren=%b wen=%b want 1 0 0 0000", i, m1_if.gnt, m0_if.gnt, ram_r_en, ram_w_en);
            end
            @(posedge clk); #1;
            tests++;
            if ({m1_if.rvalid, m1_if.err, m1_if.rdata, m0_if.rvalid} !== {2'b11, 32'h0, 1'b0}) begin
                fails++;
                $display("FAIL err_rsp[%0d]: got rv=%b err=%b rd=%h rv0=%b want 1 1 0 0", i, m1_if.rvalid, m1_if.err, m1_if.rdata, m0_if.rvalid);
            end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_arb();
        logic exp;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); drive(0, 0, SZ_W, 0, 32'h10, 0); drive(1, 0, SZ_W, 0, 32'h10, 0);
`ifdef DMEM_ARB_RR_EN
            exp = (c % 2 == 0);
`else
            exp = (c % 9 == 0);
`endif
            #1;
            tests++;
            if ({m0_if.gnt, m1_if.gnt} !== {~exp, exp}) begin
                fails++;
                $display("FAIL arb_gnt[%0d]: got %b%b want %b%b", c, m0_if.gnt, m1_if.gnt, ~exp, exp);
            end
            @(posedge clk); #1;
            tests++;
            if ({m0_if.rvalid, m1_if.rvalid} !== {~exp, exp}) begin
                fails++;
                $display("FAIL arb_rsp[%0d]: got %b%b want %b%b", c, m0_if.rvalid, m1_if.rvalid, ~exp, exp);
            end
        end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive(0, 0, SZ_W, 0, 32'h10, 0);
        @(posedge clk); #1; rst = 0; #1;
        tests++;
        if ({m0_if.rvalid, m0_if.err, m0_if.rdata, m0_if.gnt, ram_r_en, ram_w_en} !== 39'b0) begin
            fails++;
            $display("FAIL rst_mid: got rv=%b err=%b rd=%h gnt=%b ren=%b wen=%b want all 0", m0_if.rvalid, m0_if.err, m0_if.rdata, m0_if.gnt, ram_r_en, ram_w_en);
        end
        @(posedge clk); #1;
        tests++;
        if ({m0_if.rvalid, m0_if.gnt, ram_r_en} !== 3'b0) begin
            fails++;
            $display("FAIL rst_hold: got rv=%b gnt=%b ren=%b want 0 0 0", m0_if.rvalid, m0_if.gnt, ram_r_en);
        end
        @(negedge clk); rst = 1; #1;
        tests++;
        if ({m0_if.gnt, ram_r_en} !== 2'b11) begin
            fails++;
            $display("FAIL rst_release_gnt: got gnt=%b ren=%b want 1 1", m0_if.gnt, ram_r_en);
        end
        @(posedge clk); #1;
        tests++;
        if ({m0_if.rvalid, m0_if.err, m0_if.rdata} !== {2'b10, 32'h80A57F01}) begin
            fails++;
            $display("FAIL rst_first_ld: got rv=%b err=%b rd=%h want 1 0 80a57f01", m0_if.rvalid, m0_if.err, m0_if.rdata);
        end
        @(negedge clk); idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_store_load_word();
        test_load_ext();
        test_store_half();
        test_errors();
        test_arb();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
